fft_shift_ctrl: RTL and testbench
=================================

FFT_SHIFT_CTRL -- requirements
Module: fft_shift_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 10, the number of FFT butterfly stages and the width of shift_out.
REQ-002 SHALL have parameter CNT_W, default 16, the width of of_count.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port user_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port shift_reg_in, input, 32 bits: the software shift register value, already in the user_clk domain. Bits [N_STAGES-1:0] are the schedule; bit 31 is the counter-clear request; other bits are ignored.
REQ-006 SHALL have port sync_in, input, 1 bit: single-cycle frame-start pulse.
REQ-007 SHALL have port fft_of_in, input, 1 bit: FFT overflow indication, valid on any cycle.
REQ-008 SHALL have port shift_out, output, N_STAGES bits: the active shift schedule fed to the FFT.
REQ-009 SHALL have port sync_out, output, 1 bit: sync_in delayed to align with shift_out.
REQ-010 SHALL have port shift_valid, output, 1 bit: high once a schedule has been applied at a sync.
REQ-011 SHALL have port of_count, output, CNT_W bits: the count of frames that overflowed.
REQ-012 SHALL have port of_sticky, output, 1 bit: set on any overflowed frame.

Function
REQ-013 SHALL register shift_reg_in through two flops (cap1, cap2) and treat cap2 as the candidate schedule only when cap1 == cap2, i.e. the value is stable for 2 cycles.
REQ-014 SHALL set the pending flag when the stable candidate[N_STAGES-1:0] differs from shift_out, and clear pending when the candidate is loaded.
REQ-015 SHALL implement a state machine with states IDLE and RUN; reset enters IDLE.
REQ-016 In IDLE, on sync_in: load shift_out from the stable candidate (or from cap2 if it is unstable that cycle), set shift_valid, and go to RUN.
REQ-017 In RUN, on sync_in with pending set: load shift_out from the candidate. With pending clear, shift_out holds.
REQ-018 SHALL never change shift_out except on the cycle after sync_in is sampled; a mid-frame register write takes effect at the next sync only.
REQ-019 SHALL assert sync_out exactly 1 cycle after sync_in, which is the same cycle the updated shift_out is first visible (latency 1).
REQ-020 In RUN, SHALL set the frame_of flag on any cycle with fft_of_in=1; on sync_in, if frame_of (or fft_of_in that same cycle) then increment of_count and set of_sticky; frame_of is then cleared.
REQ-021 of_count SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-022 SHALL ignore fft_of_in in IDLE.
REQ-023 A rising edge of cap2[31] SHALL clear of_count, of_sticky and frame_of the next cycle; when the clear coincides with an increment, the clear wins.
REQ-024 Back-to-back sync_in pulses SHALL each be handled independently; a frame of 1 cycle is legal.

Reset
REQ-025 On user_rst=1 at a clock edge: shift_out=0, sync_out=0, shift_valid=0, of_count=0, of_sticky=0, pending=0, frame_of=0, cap1=cap2=0, state=IDLE.
REQ-026 Reset asserted mid-frame SHALL discard any pending schedule and overflow, and require a fresh sync_in to re-enter RUN.
REQ-027 user_rst SHALL take priority over all other inputs.

Verification
REQ-028 Reset, then shift_reg_in=0x3FF, sync_in at cycle 10 -> shift_out=0x3FF and sync_out=1 at cycle 11, shift_valid=1; before cycle 11 shift_out=0.
REQ-029 In RUN, change shift_reg_in to 0x155 mid-frame -> shift_out stays 0x3FF until the cycle after the next sync_in, then becomes 0x155.
REQ-030 Pulse fft_of_in once in each of 3 frames, then no overflow in a 4th frame -> of_count=3 and of_sticky=1 after the 4th sync.
REQ-031 Force of_count to saturate (CNT_W=4, 20 overflowed frames) -> of_count=15.
REQ-032 Set bit 31 on the same cycle as a sync with an overflowed frame -> of_count=0 and of_sticky=0.
REQ-033 Assert user_rst mid-frame with pending=1 -> all outputs 0 and state IDLE; the next sync loads the current stable register value.

Source files
------------

// File: rtl/fft_shift_ctrl.sv
// fft_shift_ctrl
//   Applies a software-written FFT shift schedule at frame boundaries and
//   counts overflowed frames.
//
//   The schedule register arrives already in the user_clk domain, but it is
//   only trusted once it has held the same value for two consecutive
//   samples. A changed schedule is marked pending and is swapped in on the
//   next sync_in. Schedules never change mid-frame.
//
// Ports
//   user_clk      : single clock
//   user_rst      : synchronous, active-high reset
//   shift_reg_in  : software register; [N_STAGES-1:0] = schedule,
//                   [31] = overflow-counter clear request (rising edge)
//   sync_in       : one-cycle frame-start pulse
//   fft_of_in     : FFT overflow indication, valid on any cycle
//   shift_out     : active shift schedule (updates 1 cycle after sync_in)
//   sync_out      : sync_in delayed 1 cycle, aligned with shift_out
//   shift_valid   : set once a schedule has been applied at a sync
//   of_count      : saturating count of frames that overflowed
//   of_sticky     : set on any overflowed frame
module fft_shift_ctrl #(
  parameter int N_STAGES = 10,
  parameter int CNT_W    = 16
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         shift_reg_in,
  input  logic                sync_in,
  input  logic                fft_of_in,
  output logic [N_STAGES-1:0] shift_out,
  output logic                sync_out,
  output logic                shift_valid,
  output logic [CNT_W-1:0]    of_count,
  output logic                of_sticky
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) sat_inc = c;
    else              sat_inc = c + CNT_ONE;
  endfunction

  logic [31:0]         cap1_q, cap2_q;
  logic                bit31_q;
  logic [0:0]          state_q, state_d;
  logic [N_STAGES-1:0] shift_q, shift_d;
  logic [N_STAGES-1:0] cand_q, cand_d;
  logic                sync_q;
  logic                valid_q, valid_d;
  logic                pending_q, pending_d;
  logic                frame_of_q, frame_of_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, sticky_d;

  logic                stable;
  logic                clr;
  logic                load;

  always_comb begin
    stable = (cap1_q == cap2_q);
    // Last stable schedule; survives a momentary unstable sample at sync.
    cand_d = stable ? cap2_q[N_STAGES-1:0] : cand_q;
    clr    = cap2_q[31] & ~bit31_q;

    state_d    = state_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    frame_of_d = frame_of_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Overflow is ignored here; the first sync always takes cap2.
        if (sync_in) begin
          shift_d = cap2_q[N_STAGES-1:0];
          valid_d = 1'b1;
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      default: begin
        frame_of_d = frame_of_q | fft_of_in;
        if (sync_in) begin
          if (pending_q) begin
            shift_d = cand_d;
            load    = 1'b1;
          end
          // An overflow on the sync cycle itself belongs to the ending frame.
          if (frame_of_q | fft_of_in) begin
            cnt_d    = sat_inc(cnt_q);
            sticky_d = 1'b1;
          end
          frame_of_d = 1'b0;
        end
      end
    endcase

    if (load)
      pending_d = 1'b0;
    else if (stable && (cap2_q[N_STAGES-1:0] != shift_q))
      pending_d = 1'b1;
    else
      pending_d = pending_q;

    // Software clear overrides any same-cycle increment.
    if (clr) begin
      cnt_d      = '0;
      sticky_d   = 1'b0;
      frame_of_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cap1_q     <= '0;
      cap2_q     <= '0;
      bit31_q    <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cand_q     <= '0;
      sync_q     <= 1'b0;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      frame_of_q <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      cap1_q     <= shift_reg_in;
      cap2_q     <= cap1_q;
      bit31_q    <= cap2_q[31];
      state_q    <= state_d;
      shift_q    <= shift_d;
      cand_q     <= cand_d;
      sync_q     <= sync_in;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      frame_of_q <= frame_of_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign shift_out   = shift_q;
  assign sync_out    = sync_q;
  assign shift_valid = valid_q;
  assign of_count    = cnt_q;
  assign of_sticky   = sticky_q;

endmodule

// File: tb/tb_fft_shift_ctrl.sv
// Testbench for fft_shift_ctrl (N_STAGES=10, CNT_W=4 so saturation is reachable).
module tb_fft_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sr;
  logic        sync_i;
  logic        of_i;
  logic [9:0]  shift_o;
  logic        sync_o;
  logic        valid_o;
  logic [3:0]  cnt_o;
  logic        sticky_o;

  int checks = 0;
  int errors = 0;

  fft_shift_ctrl #(.N_STAGES(10), .CNT_W(4)) dut (
    .user_clk    (clk),
    .user_rst    (rst),
    .shift_reg_in(sr),
    .sync_in     (sync_i),
    .fft_of_in   (of_i),
    .shift_out   (shift_o),
    .sync_out    (sync_o),
    .shift_valid (valid_o),
    .of_count    (cnt_o),
    .of_sticky   (sticky_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sr;
    logic        sync;
    logic        of;
    logic [9:0]  shift;
    logic        so;
    logic        vld;
    logic [3:0]  cnt;
    logic        stk;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t v(input logic [31:0] s, input logic sy, input logic o,
                             input logic [9:0] sh, input logic so, input logic vl,
                             input logic [3:0] c, input logic st);
    vec_t r;
    r.sr = s; r.sync = sy; r.of = o; r.shift = sh;
    r.so = so; r.vld = vl; r.cnt = c; r.stk = st;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] sh, input logic so,
                         input logic vl, input logic [3:0] c, input logic st);
    chk($sformatf("%s shift_out", tag),   {22'b0, shift_o},  {22'b0, sh});
    chk($sformatf("%s sync_out", tag),    {31'b0, sync_o},   {31'b0, so});
    chk($sformatf("%s shift_valid", tag), {31'b0, valid_o},  {31'b0, vl});
    chk($sformatf("%s of_count", tag),    {28'b0, cnt_o},    {28'b0, c});
    chk($sformatf("%s of_sticky", tag),   {31'b0, sticky_o}, {31'b0, st});
  endtask

  initial begin
    // Load, mid-frame rewrite, overflow counting, back-to-back syncs.
    vecs[0]  = v(32'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    vecs[1]  = v(32'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    vecs[2]  = v(32'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    vecs[3]  = v(32'h3FF, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 4'd0, 1'b0); // IDLE: of ignored
    vecs[4]  = v(32'h3FF, 1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1, 4'd0, 1'b0); // first sync
    vecs[5]  = v(32'h3FF, 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b1, 4'd0, 1'b0); // overflow in frame
    vecs[6]  = v(32'h155, 1'b0, 1'b0, 10'h3FF, 1'b0, 1'b1, 4'd0, 1'b0); // mid-frame write
    vecs[7]  = v(32'h155, 1'b0, 1'b0, 10'h3FF, 1'b0, 1'b1, 4'd0, 1'b0);
    vecs[8]  = v(32'h155, 1'b0, 1'b0, 10'h3FF, 1'b0, 1'b1, 4'd0, 1'b0);
    vecs[9]  = v(32'h155, 1'b1, 1'b0, 10'h155, 1'b1, 1'b1, 4'd1, 1'b1); // swap + count
    vecs[10] = v(32'h155, 1'b0, 1'b0, 10'h155, 1'b0, 1'b1, 4'd1, 1'b1);
    vecs[11] = v(32'h155, 1'b1, 1'b1, 10'h155, 1'b1, 1'b1, 4'd2, 1'b1); // of on sync cycle
    vecs[12] = v(32'h155, 1'b1, 1'b0, 10'h155, 1'b1, 1'b1, 4'd2, 1'b1); // frame_of cleared
    vecs[13] = v(32'h155, 1'b1, 1'b1, 10'h155, 1'b1, 1'b1, 4'd3, 1'b1); // 1-cycle frame
    vecs[14] = v(32'h155, 1'b0, 1'b0, 10'h155, 1'b0, 1'b1, 4'd3, 1'b1);
    vecs[15] = v(32'h155, 1'b1, 1'b0, 10'h155, 1'b1, 1'b1, 4'd3, 1'b1); // clean frame

    rst = 1'b1; sr = 32'h0; sync_i = 1'b0; of_i = 1'b0;
    step();
    step();
    chk_all("reset", 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      sr = vecs[i].sr; sync_i = vecs[i].sync; of_i = vecs[i].of;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].shift, vecs[i].so, vecs[i].vld,
              vecs[i].cnt, vecs[i].stk);
    end

    // Saturation: 20 overflowed frames on a 4-bit counter starting at 3.
    for (int i = 0; i < 20; i++) begin
      sync_i = 1'b1; of_i = 1'b1;
      step();
      chk($sformatf("sat frame%0d of_count", i), {28'b0, cnt_o},
          (3 + i + 1 > 15) ? 32'd15 : 32'(3 + i + 1));
      sync_i = 1'b0; of_i = 1'b0;
      step();
    end

    // Counter clear: bit 31 set together with an overflowed sync, and the
    // clear request reaching the counter on another overflowed sync.
    sr = 32'h8000_0155; sync_i = 1'b1; of_i = 1'b1;
    step();
    chk("clr t0 of_count", {28'b0, cnt_o}, 32'd15);
    sync_i = 1'b0; of_i = 1'b0;
    step();
    chk("clr t1 of_count", {28'b0, cnt_o}, 32'd15);
    sync_i = 1'b1; of_i = 1'b1;
    step();
    chk_all("clr wins", 10'h155, 1'b1, 1'b1, 4'd0, 1'b0);
    sync_i = 1'b0; of_i = 1'b0;
    step();
    sync_i = 1'b1;
    step();
    chk("after clr frame_of cleared", {28'b0, cnt_o}, 32'd0);
    sync_i = 1'b1; of_i = 1'b1;
    step();
    chk("after clr counts again", {28'b0, cnt_o}, 32'd1);
    chk("after clr sticky", {31'b0, sticky_o}, 32'd1);
    sync_i = 1'b0; of_i = 1'b0;

    // Reset mid-frame with a pending schedule and a pending overflow.
    sr = 32'h0AA; of_i = 1'b1;
    step();
    step();
    step();
    chk("pre-rst shift holds", {22'b0, shift_o}, 32'h155);
    of_i = 1'b0; rst = 1'b1;
    step();
    chk_all("midframe rst", 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    step();
    step();
    step();
    chk_all("post-rst idle", 10'h000, 1'b0, 1'b0, 4'd0, 1'b0);
    sync_i = 1'b1; of_i = 1'b1;
    step();
    chk_all("post-rst sync", 10'h0AA, 1'b1, 1'b1, 4'd0, 1'b0);
    sync_i = 1'b0; of_i = 1'b0;
    step();
    sync_i = 1'b1;
    step();
    chk_all("post-rst 2nd sync", 10'h0AA, 1'b1, 1'b1, 4'd0, 1'b0);
    sync_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
